arb2_mux_ctrl: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 3-bit 2:1 multiplexer path. It accepts request/grant handshakes from two sources and drives the mux select. It bounds each grant to a programmable burst length and registers the selected 3-bit word with a valid strobe for the downstream consumer. It sits directly in front of the 3-bit 2:1 mux and is the only block that drives that mux's select line.

---
 rtl/arb2_mux_ctrl_if.sv | 26 ++
 rtl/arb2_mux_ctrl.sv | 112 +++++++++++
 tb/tb_arb2_mux_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/arb2_mux_ctrl_if.sv
// Request/grant and data bus between the two sources, the arbiter and the
// downstream consumer of the selected word.
interface arb2_mux_ctrl_if #(
    parameter int DATA_W = 3
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] in0;
    logic [DATA_W-1:0] in1;
    logic              gnt0;
    logic              gnt1;
    logic              sel;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              busy;

    modport master (
        output req0, req1, in0, in1,
        input  gnt0, gnt1, sel, out, out_valid, busy
    );

    modport slave (
        input  req0, req1, in0, in1,
        output gnt0, gnt1, sel, out, out_valid, busy
    );
endinterface

// File: rtl/arb2_mux_ctrl.sv
// Two-source round-robin arbiter driving the select of a 2:1 mux, with
// bounded burst length and a registered output word plus valid strobe.
module arb2_mux_ctrl #(
    parameter int HOLD_MAX = 4,
    parameter int DATA_W   = 3
) (
    input logic            clk,
    input logic            rst_n,
    arb2_mux_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t            state;
    state_t            next_state;
    logic              last;
    logic [3:0]        hold_cnt;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              sel_q;
    logic              busy_q;
    logic [DATA_W-1:0] out_q;
    logic              out_valid_q;
    logic              hold_done;

    // Forced rotation fires only while both sources are requesting.
    assign hold_done = (hold_cnt == HOLD_LAST);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.req0 && bus.req1)
                    next_state = last ? GNT0 : GNT1;
                else if (bus.req0)
                    next_state = GNT0;
                else if (bus.req1)
                    next_state = GNT1;
            end
            GNT0: begin
                if (!bus.req0)
                    next_state = bus.req1 ? GNT1 : IDLE;
                else if (bus.req1 && hold_done)
                    next_state = GNT1;
            end
            GNT1: begin
                if (!bus.req1)
                    next_state = bus.req0 ? GNT0 : IDLE;
                else if (bus.req0 && hold_done)
                    next_state = GNT0;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            hold_cnt    <= 4'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state  <= next_state;
            gnt0_q <= (next_state == GNT0);
            gnt1_q <= (next_state == GNT1);
            sel_q  <= (next_state == GNT1);
            busy_q <= (next_state != IDLE);

            // Counter restarts on every grant entry and wraps naturally at 15.
            if (next_state != state)
                hold_cnt <= 4'd0;
            else if (state != IDLE)
                hold_cnt <= hold_cnt + 4'd1;

            if (next_state != state) begin
                if (next_state == GNT0)
                    last <= 1'b0;
                else if (next_state == GNT1)
                    last <= 1'b1;
            end

            unique case (state)
                GNT0: begin
                    out_q       <= bus.in0;
                    out_valid_q <= 1'b1;
                end
                GNT1: begin
                    out_q       <= bus.in1;
                    out_valid_q <= 1'b1;
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Bench for arb2_mux_ctrl: two instances (HOLD_MAX=4 and HOLD_MAX=1) share the
// same stimulus and are compared each cycle against a grant-ownership model.
module tb_arb2_mux_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       r0 = 1'b0;
    logic       r1 = 1'b0;
    logic [2:0] d0 = 3'b000;
    logic [2:0] d1 = 3'b000;

    arb2_mux_ctrl_if #(.DATA_W(3)) bus_a ();
    arb2_mux_ctrl_if #(.DATA_W(3)) bus_b ();

    assign bus_a.req0 = r0;
    assign bus_a.req1 = r1;
    assign bus_a.in0  = d0;
    assign bus_a.in1  = d1;
    assign bus_b.req0 = r0;
    assign bus_b.req1 = r1;
    assign bus_b.in0  = d0;
    assign bus_b.in1  = d1;

    arb2_mux_ctrl #(.HOLD_MAX(4), .DATA_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    arb2_mux_ctrl #(.HOLD_MAX(1), .DATA_W(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int failures = 0;

    // Model: who owns the path (-1 none), how many consecutive cycles it has
    // held it, and who was granted most recently.
    int         hold_max [2] = '{4, 1};
    int         own  [2];
    int         run  [2];
    int         prev [2];
    logic [2:0] eout [2];
    logic       evld [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]  = -1;
            run[k]  = 0;
            prev[k] = 1;
            eout[k] = 3'b000;
            evld[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nxt;
            int x;
            int y;
            bit want [2];
            want[0] = r0;
            want[1] = r1;
            if (own[k] >= 0) begin
                evld[k] = 1'b1;
                eout[k] = (own[k] == 0) ? d0 : d1;
            end else begin
                evld[k] = 1'b0;
            end
            if (own[k] < 0) begin
                if (want[0] && want[1]) nxt = 1 - prev[k];
                else if (want[0])       nxt = 0;
                else if (want[1])       nxt = 1;
                else                    nxt = -1;
            end else begin
                x = own[k];
                y = 1 - x;
                if (!want[x])
                    nxt = want[y] ? y : -1;
                else if (want[y] && (((run[k] - 1) % 16) == hold_max[k] - 1))
                    nxt = y;
                else
                    nxt = x;
            end
            if (nxt != own[k]) begin
                run[k] = (nxt >= 0) ? 1 : 0;
                if (nxt >= 0) prev[k] = nxt;
            end else if (nxt >= 0) begin
                run[k] = run[k] + 1;
            end
            own[k] = nxt;
        end
    endtask

    function automatic logic [7:0] expv(int k);
        return {own[k] == 0, own[k] == 1, own[k] == 1, own[k] >= 0, evld[k], eout[k]};
    endfunction

    function automatic logic [7:0] obs_a();
        return {bus_a.gnt0, bus_a.gnt1, bus_a.sel, bus_a.busy, bus_a.out_valid, bus_a.out};
    endfunction

    function automatic logic [7:0] obs_b();
        return {bus_b.gnt0, bus_b.gnt1, bus_b.sel, bus_b.busy, bus_b.out_valid, bus_b.out};
    endfunction

    task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed={g0,g1,sel,busy,vld,out}=%b expected=%b",
                   tag, observed, expected);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "/hm4"}, obs_a(), expv(0));
        check({tag, "/hm1"}, obs_b(), expv(1));
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Asynchronous reset from power-up, mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check("rst_init/hm4", obs_a(), 8'h00);
        check("rst_init/hm1", obs_b(), 8'h00);
        #9 rst_n = 1'b1;

        // Single requester for 3 cycles, then release.
        d0 = 3'b101;
        r0 = 1'b1;
        for (int i = 0; i < 3; i++) cycle("single");
        r0 = 1'b0;
        for (int i = 0; i < 4; i++) cycle("single_tail");
        check("single_idle_gnt0", {7'd0, bus_a.gnt0}, 8'h00);

        // Tie after a fresh reset goes to source 0.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        d0 = 3'b001;
        d1 = 3'b110;
        r0 = 1'b1;
        r1 = 1'b1;
        cycle("tie");
        check("tie_first_gnt0", {6'd0, bus_a.gnt0, bus_a.gnt1}, 8'h02);

        // Sustained contention.
        for (int i = 0; i < 20; i++) cycle("contend");

        // Early release in GNT1 with source 0 still waiting.
        for (int i = 0; i < 10 && own[0] != 1; i++) cycle("seek_gnt1");
        r1 = 1'b0;
        cycle("early_rel");
        check("early_rel_gnt0", {6'd0, bus_a.gnt0, bus_a.gnt1}, 8'h02);
        r1 = 1'b1;
        for (int i = 0; i < 10; i++) cycle("after_rel");

        // Reset pulse during GNT1 with hold count at 2.
        for (int i = 0; i < 12 && !(own[0] == 1 && run[0] == 3); i++) cycle("seek_cnt2");
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/hm4", obs_a(), 8'h00);
        check("rst_mid/hm1", obs_b(), 8'h00);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        cycle("post_rst");
        check("post_rst_gnt0", {6'd0, bus_a.gnt0, bus_a.gnt1}, 8'h02);
        for (int i = 0; i < 6; i++) cycle("post_rst_run");

        // Randomized traffic, biased toward contention.
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            d0 = 3'($urandom_range(0, 7));
            d1 = 3'($urandom_range(0, 7));
            cycle("random");
        end

        // Long solo hold to cross the counter wrap, then contention.
        r0 = 1'b1;
        r1 = 1'b0;
        for (int i = 0; i < 18; i++) cycle("solo_wrap");
        r1 = 1'b1;
        for (int i = 0; i < 12; i++) cycle("wrap_contend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
